// File: rtl/gpo_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : gpo_event_scheduler
// Brief   : Timed-event sequencer for one GPO core. Timestamped 128-bit words
//           are queued in a FIFO; the head entry is released as a one-cycle
//           counter_matched pulse (with gpo_data) once the global timestamp
//           reaches its scheduled time. Reports late and overflow events.
//           Optional macro GPO_SCHED_ERR_CNT_EN adds saturating counters for
//           the core's busy_error / overrided events.
// Revision: 1.0 - initial release
// ============================================================================
module gpo_event_scheduler #(
  parameter int FIFO_DEPTH = 16,
  parameter int TIME_WIDTH = 64
) (
  input  logic                          CLK100MHZ,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [TIME_WIDTH-1:0]         wr_time,
  input  logic [127:0]                  wr_data,
  input  logic                          run,
  input  logic                          flush,
  input  logic                          clear_err,
  input  logic [TIME_WIDTH-1:0]         timestamp,
  input  logic                          gpo_busy,
  input  logic                          core_busy_error,
  input  logic                          core_overrided,
  output logic                          counter_matched,
  output logic [127:0]                  gpo_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          late_error,
  output logic [TIME_WIDTH-1:0]         late_time,
  output logic                          overflow
`ifdef GPO_SCHED_ERR_CNT_EN
  ,
  output logic [15:0]                   busy_err_cnt,
  output logic [15:0]                   ovr_cnt
`endif
);

  localparam int              c_AW    = $clog2(FIFO_DEPTH);
  localparam logic [c_AW:0]   c_DEPTH = (c_AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_FIRE = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [TIME_WIDTH-1:0] r_mem_time [FIFO_DEPTH];
  logic [127:0]          r_mem_data [FIFO_DEPTH];
  logic [c_AW-1:0]       r_wr_ptr;
  logic [c_AW-1:0]       r_rd_ptr;
  logic [c_AW:0]         r_count;

  // Sequencer state and the loaded head entry
  state_t                r_state;
  logic [TIME_WIDTH-1:0] r_head_time;
  logic [127:0]          r_head_data;

  logic w_fifo_empty;
  logic w_push;
  logic w_pop;
  logic w_go;
  logic w_fire;
  logic w_late;
  logic w_ovf;

  assign w_fifo_empty = (r_count == '0);
  assign full         = (r_count == c_DEPTH);
  assign fifo_level   = r_count;
  // The head register counts as content only while it waits for its time.
  assign empty        = w_fifo_empty & (r_state != S_WAIT);

  // flush blocks both ends of the FIFO in its cycle.
  assign w_push = wr_en & ~full & ~flush;
  // The next entry is fetched in LOAD, or directly in FIRE so that
  // back-to-back due entries go out every second cycle.
  assign w_pop  = ~flush & ((r_state == S_LOAD) |
                            ((r_state == S_FIRE) & ~w_fifo_empty));

  assign w_go   = run & ~gpo_busy & (timestamp >= r_head_time);
  assign w_fire = ~flush & (r_state == S_WAIT) & w_go;
  assign w_late = w_fire & (timestamp > r_head_time);
  // A write against a full FIFO is an overflow even if it coincides with flush.
  assign w_ovf  = wr_en & full;

  // FIFO storage write port (no reset, plain RAM)
  always_ff @(posedge CLK100MHZ) begin
    if (w_push) begin
      r_mem_time[r_wr_ptr] <= wr_time;
      r_mem_data[r_wr_ptr] <= wr_data;
    end
  end

  // FIFO pointers and occupancy; flush empties the queue
  always_ff @(posedge CLK100MHZ) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_AW+1)'(1);
        2'b01:   r_count <= r_count - (c_AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Dispatch sequencer with registered pulse and data outputs
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_head_time     <= '0;
      r_head_data     <= '0;
      counter_matched <= 1'b0;
      gpo_data        <= '0;
    end else if (flush) begin
      r_state         <= S_IDLE;
      counter_matched <= 1'b0;
    end else begin
      counter_matched <= 1'b0;
      if (w_pop) begin
        r_head_time <= r_mem_time[r_rd_ptr];
        r_head_data <= r_mem_data[r_rd_ptr];
      end
      case (r_state)
        S_IDLE: begin
          if (!w_fifo_empty) begin
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_go) begin
            counter_matched <= 1'b1;
            gpo_data        <= r_head_data;
            r_state         <= S_FIRE;
          end
        end
        S_FIRE: begin
          // When another entry is queued it was fetched this cycle.
          r_state <= w_fifo_empty ? S_IDLE : S_WAIT;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Sticky late / overflow flags; a new event outranks clear_err
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      late_error <= 1'b0;
      late_time  <= '0;
      overflow   <= 1'b0;
    end else begin
      if (w_late) begin
        late_error <= 1'b1;
        late_time  <= timestamp;
      end else if (clear_err) begin
        late_error <= 1'b0;
        late_time  <= '0;
      end
      if (w_ovf) begin
        overflow <= 1'b1;
      end else if (clear_err) begin
        overflow <= 1'b0;
      end
    end
  end

`ifdef GPO_SCHED_ERR_CNT_EN
  // Saturating core error counters; an increment outranks clear_err
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      busy_err_cnt <= '0;
      ovr_cnt      <= '0;
    end else begin
      if (core_busy_error) begin
        if (clear_err) begin
          busy_err_cnt <= 16'd1;
        end else if (busy_err_cnt != 16'hFFFF) begin
          busy_err_cnt <= busy_err_cnt + 16'd1;
        end
      end else if (clear_err) begin
        busy_err_cnt <= '0;
      end
      if (core_overrided) begin
        if (clear_err) begin
          ovr_cnt <= 16'd1;
        end else if (ovr_cnt != 16'hFFFF) begin
          ovr_cnt <= ovr_cnt + 16'd1;
        end
      end else if (clear_err) begin
        ovr_cnt <= '0;
      end
    end
  end
`else
  // Core error inputs are not observed in this build.
  logic w_unused_core;
  assign w_unused_core = core_busy_error ^ core_overrided;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gpo_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_gpo_event_scheduler
// Brief   : Directed self-checking bench for gpo_event_scheduler.
// Revision: 1.0 - initial release
// ============================================================================
module tb_gpo_event_scheduler;

  logic          CLK100MHZ = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [63:0]   wr_time;
  logic [127:0]  wr_data;
  logic          run;
  logic          flush;
  logic          clear_err;
  logic [63:0]   timestamp;
  logic          gpo_busy;
  logic          core_busy_error;
  logic          core_overrided;
  logic          counter_matched;
  logic [127:0]  gpo_data;
  logic          full;
  logic          empty;
  logic [4:0]    fifo_level;
  logic          late_error;
  logic [63:0]   late_time;
  logic          overflow;
`ifdef GPO_SCHED_ERR_CNT_EN
  logic [15:0]   busy_err_cnt;
  logic [15:0]   ovr_cnt;
`endif

  gpo_event_scheduler #(
    .FIFO_DEPTH (16),
    .TIME_WIDTH (64)
  ) dut (
    .CLK100MHZ       (CLK100MHZ),
    .reset           (reset),
    .wr_en           (wr_en),
    .wr_time         (wr_time),
    .wr_data         (wr_data),
    .run             (run),
    .flush           (flush),
    .clear_err       (clear_err),
    .timestamp       (timestamp),
    .gpo_busy        (gpo_busy),
    .core_busy_error (core_busy_error),
    .core_overrided  (core_overrided),
    .counter_matched (counter_matched),
    .gpo_data        (gpo_data),
    .full            (full),
    .empty           (empty),
    .fifo_level      (fifo_level),
    .late_error      (late_error),
    .late_time       (late_time),
    .overflow        (overflow)
`ifdef GPO_SCHED_ERR_CNT_EN
    ,
    .busy_err_cnt    (busy_err_cnt),
    .ovr_cnt         (ovr_cnt)
`endif
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // Pulse log: cycle number, data and timestamp applied at the firing edge
  int           p_cyc  [$];
  logic [127:0] p_data [$];
  logic [63:0]  p_ts   [$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock; outputs are sampled 1 ns after the rising edge
  task automatic step();
    @(posedge CLK100MHZ);
    #1;
    cyc++;
    if (counter_matched === 1'b1) begin
      p_cyc.push_back(cyc);
      p_data.push_back(gpo_data);
      p_ts.push_back(timestamp);
    end
  endtask

  task automatic clear_log();
    p_cyc.delete();
    p_data.delete();
    p_ts.delete();
  endtask

  task automatic push_entry(input logic [63:0] t, input logic [127:0] d);
    wr_en   = 1'b1;
    wr_time = t;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
  endtask

  int base;

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_time = '0; wr_data = '0; run = 1'b0;
    flush = 1'b0; clear_err = 1'b0; timestamp = 64'd100; gpo_busy = 1'b0;
    core_busy_error = 1'b0; core_overrided = 1'b0;
    #2;
    step();
    step();
    reset = 1'b0;

    // Reset state
    chk("rst_cm",    counter_matched, 0);
    chk("rst_data",  gpo_data, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full",  full, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_late",  late_error, 0);
    chk("rst_ltime", late_time, 0);
    chk("rst_ovf",   overflow, 0);

    // 1: future entry dispatched the cycle after timestamp reaches it
    clear_log();
    run = 1'b1;
    push_entry(64'd105, 128'hA);
    chk("t1_notempty", empty, 0);
    for (int i = 1; i <= 15; i++) begin
      timestamp = 64'd100 + 64'(i);
      step();
    end
    chk("t1_npulse", p_cyc.size(), 1);
    if (p_cyc.size() > 0) begin
      chk("t1_ts",   p_ts[0], 105);
      chk("t1_data", p_data[0], 128'hA);
    end
    chk("t1_late",  late_error, 0);
    chk("t1_empty", empty, 1);

    // 2: three past-due entries, pulses 2 cycles apart, first one 4 after write
    clear_log();
    timestamp = 64'd200;
    base = cyc;
    push_entry(64'd50, 128'hD1);
    push_entry(64'd60, 128'hD2);
    push_entry(64'd70, 128'hD3);
    for (int i = 0; i < 9; i++) step();
    chk("t2_npulse", p_cyc.size(), 3);
    for (int k = 0; k < 3 && k < p_cyc.size(); k++) begin
      chk($sformatf("t2_cyc%0d", k),  p_cyc[k] - base, 4 + 2 * k);
      chk($sformatf("t2_data%0d", k), p_data[k], 128'hD1 + 128'(k));
    end
    chk("t2_late",  late_error, 1);
    chk("t2_ltime", late_time, 200);
    chk("t2_hold",  gpo_data, 128'hD3);
    chk("t2_cm0",   counter_matched, 0);

    // 3: busy holds a due entry; it goes out the cycle after busy drops
    pulse_clear();
    chk("t3_clr_late", late_error, 0);
    chk("t3_clr_lt",   late_time, 0);
    clear_log();
    timestamp = 64'd300;
    gpo_busy  = 1'b1;
    push_entry(64'd0, 128'hB);
    for (int i = 0; i < 9; i++) step();
    chk("t3_busy_np", p_cyc.size(), 0);
    chk("t3_held",    empty, 0);
    gpo_busy = 1'b0;
    step();
    chk("t3_npulse", p_cyc.size(), 1);
    if (p_cyc.size() > 0) begin
      chk("t3_when", p_cyc[0], cyc);
      chk("t3_data", p_data[0], 128'hB);
    end

    // 4: first write becomes the head, next 16 fill the FIFO, one more drops
    pulse_clear();
    clear_log();
    run = 1'b0;
    for (int i = 0; i < 17; i++) push_entry(64'd0, 128'h400 + 128'(i));
    chk("t4_level", fifo_level, 16);
    chk("t4_full",  full, 1);
    chk("t4_ovf0",  overflow, 0);
    // Overflow write together with clear_err: the event wins
    wr_en = 1'b1; wr_time = '0; wr_data = 128'hDEAD; clear_err = 1'b1;
    step();
    wr_en = 1'b0; clear_err = 1'b0;
    chk("t4_ovf",    overflow, 1);
    chk("t4_level2", fifo_level, 16);
    chk("t4_lclr",   late_error, 0);
    run = 1'b1;
    for (int i = 0; i < 40; i++) step();
    chk("t4_npulse", p_cyc.size(), 17);
    for (int k = 0; k < p_cyc.size(); k++) begin
      chk($sformatf("t4_data%0d", k), p_data[k], 128'h400 + 128'(k));
    end
    chk("t4_notfull", full, 0);
    pulse_clear();
    chk("t4_ovfclr", overflow, 0);

    // 5: flush during WAIT discards queue and head, drops the same-cycle write
    clear_log();
    run = 1'b0;
    for (int i = 0; i < 4; i++) push_entry(64'd0, 128'h500 + 128'(i));
    step();
    step();
    chk("t5_level", fifo_level, 3);
    chk("t5_nempty", empty, 0);
    flush = 1'b1; run = 1'b1; wr_en = 1'b1; wr_data = 128'h5FF;
    step();
    flush = 1'b0; wr_en = 1'b0;
    chk("t5_empty", empty, 1);
    chk("t5_lvl0",  fifo_level, 0);
    chk("t5_cm",    counter_matched, 0);
    for (int i = 0; i < 10; i++) step();
    chk("t5_npulse", p_cyc.size(), 0);

`ifdef GPO_SCHED_ERR_CNT_EN
    // 6: saturating core error counters
    for (int i = 0; i < 3; i++) begin
      core_busy_error = 1'b1; step();
      core_busy_error = 1'b0; step();
    end
    for (int i = 0; i < 2; i++) begin
      core_overrided = 1'b1; step();
      core_overrided = 1'b0; step();
    end
    chk("t6_be3",  busy_err_cnt, 3);
    chk("t6_ov2",  ovr_cnt, 2);
    pulse_clear();
    chk("t6_be0",  busy_err_cnt, 0);
    chk("t6_ov0",  ovr_cnt, 0);
    core_busy_error = 1'b1; clear_err = 1'b1;
    step();
    clear_err = 1'b0; core_busy_error = 1'b0;
    chk("t6_incclr", busy_err_cnt, 1);
    pulse_clear();
    core_busy_error = 1'b1;
    for (int i = 0; i < 65535; i++) step();
    chk("t6_max", busy_err_cnt, 16'hFFFF);
    step();
    core_busy_error = 1'b0;
    chk("t6_sat", busy_err_cnt, 16'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
